// File: rtl/ip_lb_build.sv
//============================================================================
// Module   : ip_lb_build
// Brief    : Transmit-side IP-format NoC message builder. Turns one
//            descriptor plus a payload flit stream into HDR / META / DATA
//            framing, with `last` on the final flit of the message.
// Options  : IP_LB_BUILD_LEN_CHECK_EN - when defined, compares the producer's
//            end-of-payload marker with the descriptor length and pulses
//            ip_build_len_err on disagreement.
// Revision : 1.0 - initial release
//============================================================================
`default_nettype none

`ifndef NOC_DATA_WIDTH
`define NOC_DATA_WIDTH 512
`endif
`ifndef XY_WIDTH
`define XY_WIDTH 8
`endif
`ifndef MSG_TYPE_WIDTH
`define MSG_TYPE_WIDTH 8
`endif
`ifndef MSG_LENGTH_WIDTH
`define MSG_LENGTH_WIDTH 22
`endif

// Header flit layout, MSB first:
//   dst_x | dst_y | dst_fbits(4) | msg_len | msg_type | src_x | src_y |
//   src_fbits(4) | metadata_flits(8) | padding
// Metadata flit layout, MSB first:
//   src_ip(32) | dst_ip(32) | protocol(8) | data_payload_len(LEN_W) | padding
module ip_lb_build #(
   parameter int NOC_DATA_W = `NOC_DATA_WIDTH,
   parameter int LEN_W      = 16
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        src_ip_build_req_val,
   output logic                        ip_build_src_req_rdy,
   input  logic [`XY_WIDTH-1:0]        src_ip_build_req_dst_x,
   input  logic [`XY_WIDTH-1:0]        src_ip_build_req_dst_y,
   input  logic [`MSG_TYPE_WIDTH-1:0]  src_ip_build_req_msg_type,
   input  logic [31:0]                 src_ip_build_req_src_ip,
   input  logic [31:0]                 src_ip_build_req_dst_ip,
   input  logic [7:0]                  src_ip_build_req_protocol,
   input  logic [LEN_W-1:0]            src_ip_build_req_len,
   input  logic                        src_ip_build_data_val,
   input  logic [NOC_DATA_W-1:0]       src_ip_build_data,
   input  logic                        src_ip_build_data_last,
   output logic                        ip_build_src_data_rdy,
   output logic                        ip_build_dst_val,
   output logic [NOC_DATA_W-1:0]       ip_build_dst_data,
   output logic                        ip_build_dst_last,
   input  logic                        dst_ip_build_rdy,
   output logic                        ip_build_len_err
);

   localparam int c_FLIT_BYTES = NOC_DATA_W / 8;
   localparam int c_FB_LOG2    = $clog2(c_FLIT_BYTES);
   localparam int c_XY_W       = `XY_WIDTH;
   localparam int c_MT_W       = `MSG_TYPE_WIDTH;
   localparam int c_ML_W       = `MSG_LENGTH_WIDTH;
   localparam int c_HDR_PAD_W  = NOC_DATA_W - (4 * c_XY_W + 16 + c_ML_W + c_MT_W);
   localparam int c_META_PAD_W = NOC_DATA_W - (72 + LEN_W);
   // Round-up addend, one bit wider than the length so the maximum length
   // cannot wrap.
   localparam logic [LEN_W:0] c_ROUND = (LEN_W + 1)'(c_FLIT_BYTES - 1);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_HDR  = 2'd1,
      ST_META = 2'd2,
      ST_DATA = 2'd3
   } state_t;

   state_t                 r_state;
   state_t                 w_state_nxt;

   logic [c_XY_W-1:0]      r_dst_x;
   logic [c_XY_W-1:0]      r_dst_y;
   logic [c_MT_W-1:0]      r_msg_type;
   logic [31:0]            r_src_ip;
   logic [31:0]            r_dst_ip;
   logic [7:0]             r_protocol;
   logic [LEN_W-1:0]       r_len;
   logic [LEN_W:0]         r_data_flits;
   logic [LEN_W:0]         r_rem_cnt;

   logic [LEN_W:0]         w_ceil_sum;
   logic [LEN_W:0]         w_req_flits;
   logic [c_ML_W-1:0]      w_msg_len;
   logic [NOC_DATA_W-1:0]  w_hdr_flit;
   logic [NOC_DATA_W-1:0]  w_meta_flit;
   logic                   w_rem_one;
   logic                   w_no_data;
   logic                   w_accept;
   logic                   w_data_xfer;

   logic                   w_req_rdy;
   logic                   w_src_rdy;
   logic                   w_dst_val;
   logic                   w_dst_last;
   logic [NOC_DATA_W-1:0]  w_dst_data;

   assign w_ceil_sum  = {1'b0, src_ip_build_req_len} + c_ROUND;
   assign w_req_flits = w_ceil_sum >> c_FB_LOG2;
   assign w_msg_len   = c_ML_W'(r_data_flits) + c_ML_W'(1);
   assign w_rem_one   = (r_rem_cnt == (LEN_W + 1)'(1));
   assign w_no_data   = (r_data_flits == '0);
   assign w_accept    = w_req_rdy & src_ip_build_req_val;
   assign w_data_xfer = (r_state == ST_DATA) & src_ip_build_data_val & dst_ip_build_rdy;

   assign w_hdr_flit  = {r_dst_x, r_dst_y, 4'd0, w_msg_len, r_msg_type,
                         {c_XY_W{1'b0}}, {c_XY_W{1'b0}}, 4'd0, 8'd1,
                         {c_HDR_PAD_W{1'b0}}};
   assign w_meta_flit = {r_src_ip, r_dst_ip, r_protocol, r_len,
                         {c_META_PAD_W{1'b0}}};

   // State register; reset returns to IDLE and abandons any message.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Capture the descriptor and its flit count when a request is accepted.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_dst_x      <= '0;
         r_dst_y      <= '0;
         r_msg_type   <= '0;
         r_src_ip     <= '0;
         r_dst_ip     <= '0;
         r_protocol   <= '0;
         r_len        <= '0;
         r_data_flits <= '0;
      end else if (w_accept) begin
         r_dst_x      <= src_ip_build_req_dst_x;
         r_dst_y      <= src_ip_build_req_dst_y;
         r_msg_type   <= src_ip_build_req_msg_type;
         r_src_ip     <= src_ip_build_req_src_ip;
         r_dst_ip     <= src_ip_build_req_dst_ip;
         r_protocol   <= src_ip_build_req_protocol;
         r_len        <= src_ip_build_req_len;
         r_data_flits <= w_req_flits;
      end
   end

   // Remaining payload flits: loaded as META leaves, decremented per transfer.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_rem_cnt <= '0;
      end else if ((r_state == ST_META) && dst_ip_build_rdy) begin
         r_rem_cnt <= r_data_flits;
      end else if (w_data_xfer) begin
         r_rem_cnt <= r_rem_cnt - (LEN_W + 1)'(1);
      end
   end

   // Next-state and output decode; everything is forced idle while in reset.
   always_comb begin
      w_state_nxt = r_state;
      w_req_rdy   = 1'b0;
      w_src_rdy   = 1'b0;
      w_dst_val   = 1'b0;
      w_dst_last  = 1'b0;
      w_dst_data  = '0;
      case (r_state)
         ST_IDLE: begin
            w_req_rdy = 1'b1;
            if (src_ip_build_req_val) begin
               w_state_nxt = ST_HDR;
            end
         end
         ST_HDR: begin
            w_dst_val  = 1'b1;
            w_dst_data = w_hdr_flit;
            if (dst_ip_build_rdy) begin
               w_state_nxt = ST_META;
            end
         end
         ST_META: begin
            w_dst_val  = 1'b1;
            w_dst_data = w_meta_flit;
            w_dst_last = w_no_data;
            if (dst_ip_build_rdy) begin
               w_state_nxt = w_no_data ? ST_IDLE : ST_DATA;
            end
         end
         ST_DATA: begin
            w_dst_val  = src_ip_build_data_val;
            w_src_rdy  = dst_ip_build_rdy;
            w_dst_data = src_ip_build_data;
            w_dst_last = w_rem_one;
            if (w_data_xfer && w_rem_one) begin
               w_state_nxt = ST_IDLE;
            end
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
      if (rst) begin
         w_req_rdy  = 1'b0;
         w_src_rdy  = 1'b0;
         w_dst_val  = 1'b0;
         w_dst_last = 1'b0;
      end
   end

   assign ip_build_src_req_rdy  = w_req_rdy;
   assign ip_build_src_data_rdy = w_src_rdy;
   assign ip_build_dst_val      = w_dst_val;
   assign ip_build_dst_last     = w_dst_last;
   assign ip_build_dst_data     = w_dst_data;

`ifdef IP_LB_BUILD_LEN_CHECK_EN
   logic r_len_err;

   // Flag any accepted flit whose end marker disagrees with the descriptor.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_len_err <= 1'b0;
      end else begin
         r_len_err <= w_data_xfer & (src_ip_build_data_last != w_rem_one);
      end
   end

   assign ip_build_len_err = r_len_err;
`else
   logic w_unused_data_last;
   assign w_unused_data_last = src_ip_build_data_last;
   assign ip_build_len_err   = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_ip_lb_build.sv
//============================================================================
// Module   : tb_ip_lb_build
// Brief    : Self-checking bench for ip_lb_build; randomized descriptors and
//            payloads compared against a message-level reference model.
// Revision : 1.1 - failure accounting
//============================================================================
`default_nettype none

`ifndef XY_WIDTH
`define XY_WIDTH 8
`endif
`ifndef MSG_TYPE_WIDTH
`define MSG_TYPE_WIDTH 8
`endif
`ifndef MSG_LENGTH_WIDTH
`define MSG_LENGTH_WIDTH 22
`endif

module tb_ip_lb_build;

    localparam int c_NW    = 512;
    localparam int c_LEN_W = 16;
    localparam int c_FB    = c_NW / 8;
    localparam int c_XY    = `XY_WIDTH;
    localparam int c_MT    = `MSG_TYPE_WIDTH;
    localparam int c_ML    = `MSG_LENGTH_WIDTH;

    logic               clk;
    logic               rst;
    logic               req_val;
    logic               req_rdy;
    logic [c_XY-1:0]    req_dst_x;
    logic [c_XY-1:0]    req_dst_y;
    logic [c_MT-1:0]    req_msg_type;
    logic [31:0]        req_src_ip;
    logic [31:0]        req_dst_ip;
    logic [7:0]         req_protocol;
    logic [c_LEN_W-1:0] req_len;
    logic               data_val;
    logic [c_NW-1:0]    data;
    logic               data_last;
    logic               data_rdy;
    logic               dst_val;
    logic [c_NW-1:0]    dst_data;
    logic               dst_last;
    logic               dst_rdy;
    logic               len_err;

    int checks   = 0;
    int failures = 0;

    ip_lb_build #(.NOC_DATA_W(c_NW), .LEN_W(c_LEN_W)) dut (
        .clk                       (clk),
        .rst                       (rst),
        .src_ip_build_req_val      (req_val),
        .ip_build_src_req_rdy      (req_rdy),
        .src_ip_build_req_dst_x    (req_dst_x),
        .src_ip_build_req_dst_y    (req_dst_y),
        .src_ip_build_req_msg_type (req_msg_type),
        .src_ip_build_req_src_ip   (req_src_ip),
        .src_ip_build_req_dst_ip   (req_dst_ip),
        .src_ip_build_req_protocol (req_protocol),
        .src_ip_build_req_len      (req_len),
        .src_ip_build_data_val     (data_val),
        .src_ip_build_data         (data),
        .src_ip_build_data_last    (data_last),
        .ip_build_src_data_rdy     (data_rdy),
        .ip_build_dst_val          (dst_val),
        .ip_build_dst_data         (dst_data),
        .ip_build_dst_last         (dst_last),
        .dst_ip_build_rdy          (dst_rdy),
        .ip_build_len_err          (len_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference header flit built from the documented field layout.
    function automatic logic [c_NW-1:0] hdr_model(input logic [c_XY-1:0] dx, input logic [c_XY-1:0] dy,
                                                  input logic [c_MT-1:0] mt, input logic [c_ML-1:0] ml);
        return {dx, dy, 4'd0, ml, mt, {c_XY{1'b0}}, {c_XY{1'b0}}, 4'd0, 8'd1,
                {(c_NW - (4 * c_XY + 16 + c_ML + c_MT)){1'b0}}};
    endfunction

    function automatic logic [c_NW-1:0] meta_model(input logic [31:0] sip, input logic [31:0] dip,
                                                   input logic [7:0] pr, input logic [c_LEN_W-1:0] l);
        return {sip, dip, pr, l, {(c_NW - 72 - c_LEN_W){1'b0}}};
    endfunction

    function automatic logic [c_NW-1:0] rand_flit();
        logic [c_NW-1:0] f;
        for (int i = 0; i < c_NW / 32; i++) f[i*32 +: 32] = $urandom;
        return f;
    endfunction

    // One complete message. rdy_mode: 0 always ready, 1 toggling, 2 random.
    // gap: idle producer cycles before each payload flit. bad_at: payload
    // flit (1-based) whose end marker is inverted, 0 for none. abort_after:
    // payload transfers after which reset is asserted, -1 for none.
    task automatic run_msg(input int len, input int rdy_mode, input int gap,
                           input int bad_at, input int abort_after, input string tag);
        int n, got, pay_idx, gcnt, cyc, err_seen, exp_err;
        logic [c_NW-1:0] exp_q[$];
        logic [c_NW-1:0] pay_q[$];
        logic [c_NW-1:0] f, prev_data;
        logic stall_prev;
        logic [c_XY-1:0] dx, dy;
        logic [c_MT-1:0] mt;
        logic [31:0] sip, dip;
        logic [7:0] pr;

        n   = (len + c_FB - 1) / c_FB;
        dx  = c_XY'($urandom);
        dy  = c_XY'($urandom);
        mt  = c_MT'($urandom);
        sip = $urandom;
        dip = $urandom;
        pr  = 8'($urandom);
        exp_q.push_back(hdr_model(dx, dy, mt, c_ML'(n + 1)));
        exp_q.push_back(meta_model(sip, dip, pr, c_LEN_W'(len)));
        for (int i = 0; i < n; i++) begin
            f = rand_flit();
            pay_q.push_back(f);
            exp_q.push_back(f);
        end
`ifdef IP_LB_BUILD_LEN_CHECK_EN
        exp_err = (bad_at >= 1 && bad_at <= n) ? 1 : 0;
`else
        exp_err = 0;
`endif

        @(negedge clk);
        cyc = 0;
        while (req_rdy !== 1'b1 && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
        checks++;
        if (req_rdy !== 1'b1) begin
            failures++;
            $display("FAIL %s req_rdy_before: got %b expected 1", tag, req_rdy);
        end

        req_val      = 1'b1;
        req_dst_x    = dx;
        req_dst_y    = dy;
        req_msg_type = mt;
        req_src_ip   = sip;
        req_dst_ip   = dip;
        req_protocol = pr;
        req_len      = c_LEN_W'(len);
        @(negedge clk);
        req_val = 1'b0;

        got = 0; pay_idx = 0; gcnt = gap; cyc = 0; err_seen = 0;
        stall_prev = 1'b0; prev_data = '0;
        while (got < n + 2 && cyc < 20000) begin
            case (rdy_mode)
                0:       dst_rdy = 1'b1;
                1:       dst_rdy = (cyc % 2 == 0);
                default: dst_rdy = 1'($urandom);
            endcase
            if (pay_idx < n && gcnt == 0) begin
                data_val  = 1'b1;
                data      = pay_q[pay_idx];
                data_last = (pay_idx == n - 1) ^ (bad_at == pay_idx + 1);
            end else begin
                data_val  = 1'b0;
                data      = rand_flit();
                data_last = 1'b0;
            end
            #1;
            if (abort_after >= 0 && got >= 2 && pay_idx == abort_after) begin
                rst = 1'b1;
                #1;
                checks++;
                if (dst_val !== 1'b0) begin
                    failures++;
                    $display("FAIL %s dst_val_in_reset: got %b expected 0", tag, dst_val);
                end
                @(negedge clk);
                rst      = 1'b0;
                data_val = 1'b0;
                dst_rdy  = 1'b1;
                #1;
                checks++;
                if (dst_val !== 1'b0) begin
                    failures++;
                    $display("FAIL %s dst_val_after_reset: got %b expected 0", tag, dst_val);
                end
                checks++;
                if (req_rdy !== 1'b1) begin
                    failures++;
                    $display("FAIL %s idle_after_reset: req_rdy got %b expected 1", tag, req_rdy);
                end
                return;
            end
            if (len_err === 1'b1) err_seen++;
            if (got < 2) begin
                checks++;
                if (data_rdy !== 1'b0) begin
                    failures++;
                    $display("FAIL %s data_rdy_outside_data: got %b expected 0", tag, data_rdy);
                end
            end
            if (stall_prev) begin
                checks++;
                if (dst_val !== 1'b1 || dst_data !== prev_data) begin
                    failures++;
                    $display("FAIL %s stall_stable: val %b data %h expected val 1 data %h",
                             tag, dst_val, dst_data, prev_data);
                end
            end
            if (got >= 2 && !data_val) begin
                checks++;
                if (dst_val !== 1'b0) begin
                    failures++;
                    $display("FAIL %s starve_val: got %b expected 0", tag, dst_val);
                end
            end
            stall_prev = (got < 2) && (dst_val === 1'b1) && !dst_rdy;
            prev_data  = dst_data;
            if (dst_val === 1'b1 && dst_rdy) begin
                checks++;
                if (dst_data !== exp_q[got]) begin
                    failures++;
                    $display("FAIL %s flit%0d: got %h expected %h", tag, got, dst_data, exp_q[got]);
                end
                checks++;
                if (dst_last !== 1'(got == n + 1)) begin
                    failures++;
                    $display("FAIL %s last%0d: got %b expected %b", tag, got, dst_last, (got == n + 1));
                end
                got++;
            end
            if (data_val && data_rdy === 1'b1) begin
                pay_idx++;
                gcnt = gap;
            end else if (!data_val && gcnt > 0) begin
                gcnt--;
            end
            @(negedge clk);
            cyc++;
        end

        dst_rdy  = 1'b1;
        data_val = 1'b0;
        #1;
        checks++;
        if (got != n + 2) begin
            failures++;
            $display("FAIL %s flit_count: got %0d expected %0d (timeout)", tag, got, n + 2);
        end
        checks++;
        if (pay_idx != n) begin
            failures++;
            $display("FAIL %s payload_consumed: got %0d expected %0d", tag, pay_idx, n);
        end
        checks++;
        if (req_rdy !== 1'b1) begin
            failures++;
            $display("FAIL %s req_rdy_after: got %b expected 1", tag, req_rdy);
        end
        if (len_err === 1'b1) err_seen++;
        @(negedge clk);
        #1;
        if (len_err === 1'b1) err_seen++;
        checks++;
        if (err_seen != exp_err) begin
            failures++;
            $display("FAIL %s len_err_pulses: got %0d expected %0d", tag, err_seen, exp_err);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; req_val = 1'b0; data_val = 1'b0; data_last = 1'b0; dst_rdy = 1'b1;
        req_dst_x = '0; req_dst_y = '0; req_msg_type = '0; req_src_ip = '0;
        req_dst_ip = '0; req_protocol = '0; req_len = '0; data = '0;
        repeat (3) @(negedge clk);
        #1;
        checks++;
        if (dst_val !== 1'b0) begin
            failures++;
            $display("FAIL reset dst_val: got %b expected 0", dst_val);
        end
        checks++;
        if (dst_last !== 1'b0) begin
            failures++;
            $display("FAIL reset dst_last: got %b expected 0", dst_last);
        end
        checks++;
        if (data_rdy !== 1'b0) begin
            failures++;
            $display("FAIL reset data_rdy: got %b expected 0", data_rdy);
        end
        checks++;
        if (len_err !== 1'b0) begin
            failures++;
            $display("FAIL reset len_err: got %b expected 0", len_err);
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++;
        if (req_rdy !== 1'b1) begin
            failures++;
            $display("FAIL reset req_rdy: got %b expected 1", req_rdy);
        end
    endtask

    task automatic test_zero_len();      run_msg(0, 0, 0, 0, -1, "zero_len");     endtask
    task automatic test_ceiling();
        run_msg(64, 0, 0, 0, -1, "ceil_64");
        run_msg(65, 0, 0, 0, -1, "ceil_65");
    endtask
    task automatic test_backpressure();  run_msg(200, 1, 0, 0, -1, "backpressure"); endtask
    task automatic test_starvation();    run_msg(300, 0, 3, 0, -1, "starvation");   endtask
    task automatic test_len_check();     run_msg(128, 0, 0, 1, -1, "len_check");    endtask
    task automatic test_reset_mid();
        run_msg(300, 0, 0, 0, 2, "reset_mid");
        run_msg(10, 0, 0, 0, -1, "after_reset");
    endtask
    task automatic test_max_len();       run_msg(65535, 2, 0, 0, -1, "max_len");    endtask
    task automatic test_back_to_back();
        for (int k = 0; k < 8; k++) begin
            int l;
            l = $urandom_range(0, 700);
            run_msg(l, 2, $urandom_range(0, 2), ($urandom_range(0, 3) == 0) ? 1 : 0, -1, "random");
        end
    endtask

    initial begin
        test_reset();
        test_zero_len();
        test_ceiling();
        test_backpressure();
        test_starvation();
        test_len_check();
        test_reset_mid();
        test_max_len();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
